// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // The counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational operand magnitude extraction and result sign correction.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   mag_a,
    output logic [WIDTH-1:0]   mag_b,
    output logic               neg_a,
    output logic               neg_b,
    input  logic               is_div,
    input  logic               sign_a,
    input  logic               sign_b,
    input  logic [2*WIDTH-1:0] raw,
    output logic [WIDTH-1:0]   res_hi,
    output logic [WIDTH-1:0]   res_lo
);

    logic               signed_op;
    logic [2*WIDTH-1:0] raw_neg;

    assign signed_op = (op == OP_MUL) || (op == OP_DIV);
    assign neg_a     = signed_op & a[WIDTH-1];
    assign neg_b     = signed_op & b[WIDTH-1];
    assign mag_a     = neg_a ? (~a + 1'b1) : a;
    assign mag_b     = neg_b ? (~b + 1'b1) : b;

    assign raw_neg   = ~raw + 1'b1;

    always_comb begin
        res_hi = raw[2*WIDTH-1:WIDTH];
        res_lo = raw[WIDTH-1:0];
        if (is_div) begin
            // Quotient follows the sign product, remainder follows the dividend.
            if (sign_a ^ sign_b) res_lo = ~raw[WIDTH-1:0] + 1'b1;
            if (sign_a)          res_hi = ~raw[2*WIDTH-1:WIDTH] + 1'b1;
        end else if (sign_a ^ sign_b) begin
            res_hi = raw_neg[2*WIDTH-1:WIDTH];
            res_lo = raw_neg[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MUL/MULU/DIV/DIVU into HI/LO; start edge to done is WIDTH+1 edges, divide-by-zero 1 edge.
// start is ignored while busy; MULDIV_EARLY_TERM_EN lets multiplies stop once the multiplier is exhausted.
module mul_div_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_BITS = cnt_width(WIDTH);

    state_e               state, state_nxt;
    logic [CNT_BITS-1:0]  cnt;
    logic                 is_div_q, sign_a_q, sign_b_q;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [2*WIDTH-1:0]   mcand, mcand_nxt;
    logic [WIDTH-1:0]     opb, opb_nxt;
    logic [WIDTH:0]       shifted, diff;
    logic                 last;
    logic                 accept, b_zero, short_op;

    logic [WIDTH-1:0]     mag_a, mag_b, res_hi, res_lo;
    logic                 neg_a, neg_b;

    muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .op     (op),
        .a      (a),
        .b      (b),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .neg_a  (neg_a),
        .neg_b  (neg_b),
        .is_div (is_div_q),
        .sign_a (sign_a_q),
        .sign_b (sign_b_q),
        .raw    (acc_nxt),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    assign accept = start && (state != ST_RUN);
    assign b_zero = (b == '0);

`ifdef MULDIV_EARLY_TERM_EN
    assign short_op = b_zero;
`else
    assign short_op = b_zero && op[1];
`endif

    // One iteration step; acc holds the product, or {remainder, quotient} when dividing.
    always_comb begin
        acc_nxt   = acc;
        mcand_nxt = mcand;
        opb_nxt   = opb;
        shifted   = '0;
        diff      = '0;
        if (is_div_q) begin
            shifted = acc[2*WIDTH-1:WIDTH-1];
            diff    = shifted - {1'b0, opb};
            if (!diff[WIDTH])
                acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end else begin
            if (opb[0]) acc_nxt = acc + mcand;
            mcand_nxt = mcand << 1;
            opb_nxt   = opb >> 1;
        end
        last = (cnt == CNT_BITS'(1));
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div_q && (opb_nxt == '0)) last = 1'b1;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = short_op ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_nxt = short_op ? ST_DONE : ST_RUN;
                else       state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            is_div_q    <= 1'b0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            acc         <= '0;
            mcand       <= '0;
            opb         <= '0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= CNT_BITS'(WIDTH);
            is_div_q <= op[1];
            sign_a_q <= neg_a;
            sign_b_q <= neg_b;
            acc      <= op[1] ? {{WIDTH{1'b0}}, mag_a} : '0;
            mcand    <= {{WIDTH{1'b0}}, mag_a};
            opb      <= mag_b;
            if (short_op) begin
                hi          <= op[1] ? a : '0;
                lo          <= op[1] ? '1 : '0;
                div_by_zero <= op[1];
            end
        end else if (state == ST_RUN) begin
            cnt   <= cnt - CNT_BITS'(1);
            acc   <= acc_nxt;
            mcand <= mcand_nxt;
            opb   <= opb_nxt;
            if (last) begin
                hi          <= res_hi;
                lo          <= res_lo;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: results, latency, busy/done timing, reset abort.
module tb_mul_div_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic [31:0]  lat;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    exp_t sb[$];
    exp_t last_e;
    int   cyc = 0;
    int   k_edge = 0;
    int   n_vec = 0;
    int   n_err = 0;

    mul_div_unit #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        longint       sx, sy, q, r;
        logic [63:0]  p;
        logic [W-1:0] my;
        int           h;
        sx = o[0] ? longint'({32'b0, x}) : longint'($signed(x));
        sy = o[0] ? longint'({32'b0, y}) : longint'($signed(y));
        e = '0;
        e.lat = W + 1;
        if (!o[1]) begin
            p = 64'(sx * sy);
            e.hi = p[63:32];
            e.lo = p[31:0];
`ifdef MULDIV_EARLY_TERM_EN
            my = (!o[0] && y[W-1]) ? (~y + 1'b1) : y;
            h = 0;
            for (int i = 0; i < W; i++) if (my[i]) h = i;
            e.lat = (my == '0) ? 1 : h + 2;
`else
            my = '0;
            h = 0;
`endif
        end else if (y == '0) begin
            e.hi  = x;
            e.lo  = '1;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            e.lo = q[31:0];
            e.hi = r[31:0];
        end
        return e;
    endfunction

    // Call at a negedge; the following posedge is the start edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e = model(o, x, y);
        sb.push_back(e);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clock);
        #1;
        k_edge = cyc;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        check("busy_after_start", {63'b0, busy}, {63'b0, (e.lat > 1)});
        check("done_after_start", {63'b0, done}, {63'b0, (e.lat == 1)});
    endtask

    task automatic wait_done(input bit spam);
        int   n_busy;
        bit   seen;
        exp_t e;
        n_busy = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n_busy++;
            if (spam) start = (i % 3 == 0);
        end
        start = 1'b0;
        e = sb.pop_front();
        last_e = e;
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("latency", 64'(cyc - k_edge + 1), 64'(e.lat));
            check("busy_cycles", 64'(n_busy), 64'(e.lat - 1));
            check("hi", {32'b0, hi}, {32'b0, e.hi});
            check("lo", {32'b0, lo}, {32'b0, e.lo});
            check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #12;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
        check("rst_hi", {32'b0, hi}, 64'd0);
        check("rst_lo", {32'b0, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue(OP_MULU, 32'hFFFF_FFFF, 32'd2);
        wait_done(0);
        @(negedge clock);
        check("done_pulse_width", {63'b0, done}, 64'd0);
        repeat (3) @(negedge clock);
        check("hold_hi", {32'b0, hi}, {32'b0, last_e.hi});
        check("hold_lo", {32'b0, lo}, {32'b0, last_e.lo});

        issue(OP_MUL, 32'hFFFF_FFFD, 32'd5);
        wait_done(0);
        @(negedge clock);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(0);
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(0);
        @(negedge clock);

        issue(OP_DIVU, 32'd100, 32'd0);
        wait_done(0);
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(0);
        @(negedge clock);
        issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_done(0);
        @(negedge clock);

        issue(OP_MULU, 32'd5, 32'd5);
        repeat (10) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_hi", {32'b0, hi}, 64'd0);
        check("abort_lo", {32'b0, lo}, 64'd0);
        void'(sb.pop_front());
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        issue(OP_MULU, 32'd6, 32'd7);
        wait_done(1);
        @(negedge clock);

        issue(OP_MULU, 32'd7, 32'd3);
        wait_done(0);
        @(negedge clock);
        issue(OP_MULU, 32'd9, 32'd0);
        wait_done(0);
        @(negedge clock);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);

        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            issue(2'(i), $urandom, (i == 3) ? 32'd0 : 32'($urandom_range(1, 1000)));
            wait_done(0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
